ws281x_bit_gen: RTL and testbench

// - Downstream waveform stage of the WS281x TX path. Accepts one bit per handshake and drives the serial

---
 rtl/ws281x_bit_gen.sv | 151 +++++++++++++++
 tb/tb_ws281x_bit_gen.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/ws281x_bit_gen.sv
// ws281x_bit_gen: WS281x serial waveform stage.
// Each accepted bit is driven as a high phase of TnH cycles, followed by low until the
// TnS-cycle period ends. Back-to-back bits have no gap between them.
// Optional feature macro: RST_CODE_EN. When it is defined, a frame-final bit is followed
// by a RST_CYCLES-long low latch period. When it is undefined, frm_end_i is ignored.
module ws281x_bit_gen #(
    parameter int RST_CNT_W  = 16,
    parameter int RST_CYCLES = 24000
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       bit_vld_i,
    input  logic       bit_data_i,
    input  logic       frm_end_i,
    output logic       bit_rdy_o,
    input  logic [7:0] t0h_cnt_i,
    input  logic [7:0] t0s_cnt_i,
    input  logic [7:0] t1h_cnt_i,
    input  logic [7:0] t1s_cnt_i,
    output logic       busy_o,
    output logic       bit_code_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BIT   = 2'd1,
        ST_LATCH = 2'd2
    } state_t;

    // Reject a latch length that the latch counter cannot represent.
    if (RST_CYCLES < 1 || RST_CYCLES >= (1 << RST_CNT_W)) begin : g_bad_cfg
        $error("ws281x_bit_gen: RST_CYCLES must be in 1 .. 2**RST_CNT_W-1");
    end

    state_t     r_state;
    logic [7:0] r_cnt;
    logic [7:0] r_th;
    logic [7:0] r_ts;
    logic       r_code;
    logic       r_busy;

    logic [7:0] w_ts_eff;
    logic [7:0] w_cnt_nxt;
    logic [7:0] w_new_th;
    logic [7:0] w_new_ts;
    logic       w_bit_last;
    logic       w_rdy;
    logic       w_accept;

    // NOTE: decode is built from continuous assigns; every signal has exactly one
    // unconditional driver, so no latch can be inferred.
    // A zero period is treated as a one-cycle bit.
    assign w_ts_eff   = (r_ts == 8'd0) ? 8'd1 : r_ts;
    assign w_cnt_nxt  = r_cnt + 8'd1;
    assign w_bit_last = (r_state == ST_BIT) && (r_cnt == w_ts_eff - 8'd1);
    assign w_rdy      = (r_state == ST_IDLE) || w_bit_last;
    assign w_accept   = bit_vld_i && w_rdy;
    assign w_new_th   = bit_data_i ? t1h_cnt_i : t0h_cnt_i;
    assign w_new_ts   = bit_data_i ? t1s_cnt_i : t0s_cnt_i;

    assign bit_rdy_o  = w_rdy;
    assign busy_o     = r_busy;
    assign bit_code_o = r_code;

`ifdef RST_CODE_EN
    localparam logic [RST_CNT_W-1:0] LC_LAST = RST_CNT_W'(RST_CYCLES - 1);
    localparam logic [RST_CNT_W-1:0] LC_ONE  = RST_CNT_W'(1);

    logic                 r_last;
    logic [RST_CNT_W-1:0] r_lcnt;
`endif

    // FSM: bit timing, latch period and the registered line/busy outputs.
    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= ST_IDLE;
            r_cnt   <= 8'd0;
            r_th    <= 8'd0;
            r_ts    <= 8'd0;
            r_code  <= 1'b0;
            r_busy  <= 1'b0;
`ifdef RST_CODE_EN
            r_last  <= 1'b0;
            r_lcnt  <= '0;
`endif
        end else if (w_accept) begin
            // Snapshot the timing so that later config changes cannot disturb this bit.
            r_state <= ST_BIT;
            r_cnt   <= 8'd0;
            r_th    <= w_new_th;
            r_ts    <= w_new_ts;
            r_code  <= (w_new_th != 8'd0);
            r_busy  <= 1'b1;
`ifdef RST_CODE_EN
            r_last  <= frm_end_i;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_code <= 1'b0;
                    r_busy <= 1'b0;
                end
                ST_BIT: begin
                    if (w_bit_last) begin
                        r_cnt  <= 8'd0;
                        r_code <= 1'b0;
`ifdef RST_CODE_EN
                        if (r_last) begin
                            r_state <= ST_LATCH;
                            r_lcnt  <= '0;
                            r_busy  <= 1'b1;
                        end else begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end
`else
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
`endif
                    end else begin
                        r_cnt  <= w_cnt_nxt;
                        r_code <= (w_cnt_nxt < r_th);
                    end
                end
                ST_LATCH: begin
`ifdef RST_CODE_EN
                    r_code <= 1'b0;
                    if (r_lcnt == LC_LAST) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_lcnt <= r_lcnt + LC_ONE;
                    end
`else
                    r_state <= ST_IDLE;
                    r_code  <= 1'b0;
                    r_busy  <= 1'b0;
`endif
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_code  <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ws281x_bit_gen.sv
// tb_ws281x_bit_gen: directed and randomized bit streams for ws281x_bit_gen.
// The expected line, busy and ready values for every cycle come from a per-bit
// waveform model: a bit of period ts (zero treated as one) is high for its first th cycles.
// Define RST_CODE_EN to build and check the latch period.
module tb_ws281x_bit_gen;

    localparam int RST_CYCLES = 50;
`ifdef RST_CODE_EN
    localparam bit LATCH_EN = 1'b1;
`else
    localparam bit LATCH_EN = 1'b0;
`endif

    typedef struct {
        bit         data;
        bit         fe;
        logic [7:0] t0h, t0s, t1h, t1s;
    } bit_t;

    typedef struct {
        bit code;
        bit busy;
        bit rdy;
        int nxt;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       bit_vld = 1'b0;
    logic       bit_data = 1'b0;
    logic       frm_end = 1'b0;
    logic       bit_rdy;
    logic [7:0] t0h = 8'd0, t0s = 8'd0, t1h = 8'd0, t1s = 8'd0;
    logic       busy;
    logic       bit_code;

    int   n_vec = 0;
    int   n_err = 0;
    bit_t frame[$];

    ws281x_bit_gen #(
        .RST_CNT_W (16),
        .RST_CYCLES(RST_CYCLES)
    ) dut (
        .clk_i     (clk),
        .rst_n_i   (rst_n),
        .bit_vld_i (bit_vld),
        .bit_data_i(bit_data),
        .frm_end_i (frm_end),
        .bit_rdy_o (bit_rdy),
        .t0h_cnt_i (t0h),
        .t0s_cnt_i (t0s),
        .t1h_cnt_i (t1h),
        .t1s_cnt_i (t1s),
        .busy_o    (busy),
        .bit_code_o(bit_code)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic obs, input logic exp_v);
        n_vec++;
        assert (obs === exp_v)
        else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp_v);
        end
    endtask

    // Present bit idx of the frame, or withdraw valid and scramble the config when none is left.
    task automatic present(input int idx);
        if (idx < frame.size()) begin
            bit_vld  = 1'b1;
            bit_data = frame[idx].data;
            frm_end  = frame[idx].fe;
            t0h = frame[idx].t0h;
            t0s = frame[idx].t0s;
            t1h = frame[idx].t1h;
            t1s = frame[idx].t1s;
        end else begin
            bit_vld  = 1'b0;
            frm_end  = 1'b0;
            bit_data = 1'($urandom_range(0, 1));
            t0h = 8'($urandom);
            t0s = 8'($urandom);
            t1h = 8'($urandom);
            t1s = 8'($urandom);
        end
    endtask

    // Stream the whole frame with valid held and check every cycle against the model.
    task automatic run_frame(input string name);
        exp_t q[$];
        int   n;
        int   th;
        int   tse;
        n = frame.size();
        for (int i = 0; i < n; i++) begin
            th  = frame[i].data ? int'(frame[i].t1h) : int'(frame[i].t0h);
            tse = frame[i].data ? int'(frame[i].t1s) : int'(frame[i].t0s);
            if (tse == 0) tse = 1;
            for (int k = 0; k < tse; k++)
                q.push_back('{code: (k < th), busy: 1'b1, rdy: (k == tse - 1),
                              nxt: (k == 0) ? i + 1 : -1});
        end
        if (LATCH_EN && frame[n-1].fe)
            for (int k = 0; k < RST_CYCLES; k++)
                q.push_back('{code: 1'b0, busy: 1'b1, rdy: 1'b0, nxt: -1});
        q.push_back('{code: 1'b0, busy: 1'b0, rdy: 1'b1, nxt: -1});

        @(negedge clk);
        check($sformatf("%s idle_rdy", name), bit_rdy, 1'b1);
        check($sformatf("%s idle_busy", name), busy, 1'b0);
        present(0);
        for (int e = 0; e < q.size(); e++) begin
            @(negedge clk);
            check($sformatf("%s code[%0d]", name, e), bit_code, q[e].code);
            check($sformatf("%s busy[%0d]", name, e), busy, q[e].busy);
            check($sformatf("%s rdy[%0d]", name, e), bit_rdy, q[e].rdy);
            if (q[e].nxt >= 0) present(q[e].nxt);
        end
    endtask

    function automatic bit_t mk(input bit d, input bit fe, input int t0h_v, input int t0s_v,
                                input int t1h_v, input int t1s_v);
        bit_t b;
        b.data = d;
        b.fe   = fe;
        b.t0h  = 8'(t0h_v);
        b.t0s  = 8'(t0s_v);
        b.t1h  = 8'(t1h_v);
        b.t1s  = 8'(t1s_v);
        return b;
    endfunction

    initial begin
        // Reset state.
        repeat (3) @(negedge clk);
        check("reset code", bit_code, 1'b0);
        check("reset busy", busy, 1'b0);
        rst_n = 1'b1;
        #1;
        check("release rdy", bit_rdy, 1'b1);

        // Single T1 bit: 64 high, 36 low, ready in cycle 100.
        frame = {};
        frame.push_back(mk(1'b1, 1'b0, 32, 100, 64, 100));
        run_frame("single");

        // Back-to-back 1,0,1.
        frame = {};
        frame.push_back(mk(1'b1, 1'b0, 32, 100, 64, 100));
        frame.push_back(mk(1'b0, 1'b0, 32, 100, 64, 100));
        frame.push_back(mk(1'b1, 1'b0, 32, 100, 64, 100));
        run_frame("b2b");

        // Edge timings: th=0, th>ts, ts=0 (single and back-to-back).
        frame = {};
        frame.push_back(mk(1'b0, 1'b0, 0, 10, 0, 0));
        run_frame("th0");
        frame = {};
        frame.push_back(mk(1'b1, 1'b0, 0, 0, 20, 10));
        run_frame("th_gt_ts");
        frame = {};
        frame.push_back(mk(1'b0, 1'b0, 5, 0, 5, 0));
        frame.push_back(mk(1'b1, 1'b0, 5, 0, 5, 0));
        frame.push_back(mk(1'b0, 1'b0, 5, 0, 5, 0));
        run_frame("ts0");

        // Frame end on the last bit, and frame end overridden by an immediate next bit.
        frame = {};
        frame.push_back(mk(1'b1, 1'b0, 2, 6, 4, 6));
        frame.push_back(mk(1'b0, 1'b1, 2, 6, 4, 6));
        run_frame("latch");
        frame = {};
        frame.push_back(mk(1'b1, 1'b1, 2, 6, 4, 6));
        frame.push_back(mk(1'b0, 1'b0, 2, 6, 4, 6));
        run_frame("fe_skip");

        // Mid-bit asynchronous reset at cnt=10 of a T1 bit, then a full period.
        frame = {};
        frame.push_back(mk(1'b1, 1'b0, 32, 100, 64, 100));
        @(negedge clk);
        present(0);
        @(negedge clk);
        bit_vld = 1'b0;
        repeat (10) @(negedge clk);
        check("midrst pre code", bit_code, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst code", bit_code, 1'b0);
        check("midrst busy", busy, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        run_frame("after_rst");

        // Randomized frames with per-bit timing and frame-end flags.
        for (int f = 0; f < 40; f++) begin
            int nb;
            frame = {};
            nb = $urandom_range(1, 6);
            for (int i = 0; i < nb; i++)
                frame.push_back(mk(1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0),
                                   $urandom_range(0, 14), $urandom_range(0, 12),
                                   $urandom_range(0, 14), $urandom_range(0, 12)));
            run_frame($sformatf("rnd%0d", f));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
